// File: rtl/vga_plot_pkg.sv
// Shared state encoding and screen defaults for the VGA rectangle plotter.
package vga_plot_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ERASE = 2'd1;
    localparam logic [1:0] ST_DRAW  = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ERASE = ST_ERASE,
        DRAW  = ST_DRAW,
        CLEAR = ST_CLEAR
    } plot_state_t;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_COLOUR_W = 3;

    localparam logic [DEF_COLOUR_W-1:0] BLACK = '0;

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major (dx inner, dy outer) offset counter over a run-time w x h extent.
module rect_scan_counter #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic           enable,
    input  logic [X_W:0]   w,
    input  logic [Y_W:0]   h,
    output logic [X_W-1:0] dx,
    output logic [Y_W-1:0] dy,
    output logic           last
);

    logic [X_W-1:0] dx_reg;
    logic [Y_W-1:0] dy_reg;
    logic           x_end;
    logic           y_end;

    assign x_end = ({1'b0, dx_reg} == (w - 1'b1));
    assign y_end = ({1'b0, dy_reg} == (h - 1'b1));
    assign last  = x_end && y_end;
    assign dx    = dx_reg;
    assign dy    = dy_reg;

    // The final offset wraps both counters to zero, so a following sweep starts cleanly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dx_reg <= '0;
            dy_reg <= '0;
        end else if (start) begin
            dx_reg <= '0;
            dy_reg <= '0;
        end else if (enable) begin
            if (x_end) begin
                dx_reg <= '0;
                dy_reg <= y_end ? '0 : dy_reg + 1'b1;
            end else begin
                dx_reg <= dx_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_rect_plotter.sv
// Erase-then-draw box plotter with full-screen clear, one clipped pixel per clock.
module vga_rect_plotter
    import vga_plot_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = DEF_COLOUR_W,
    parameter int BOX_W    = 4,
    parameter int BOX_H    = 4,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic                iClock,
    input  logic                iResetn,
    input  logic [X_W-1:0]      iX,
    input  logic [Y_W-1:0]      iY,
    input  logic [COLOUR_W-1:0] iColour,
    input  logic                iPlotBox,
    input  logic                iClear,
    output logic [X_W-1:0]      oX,
    output logic [Y_W-1:0]      oY,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oPlot,
    output logic                oBusy,
    output logic                oDone
);

    plot_state_t         state_reg, state_next;
    logic [X_W-1:0]      old_x_reg, new_x_reg;
    logic [Y_W-1:0]      old_y_reg, new_y_reg;
    logic [COLOUR_W-1:0] new_colour_reg;
    logic                valid_reg, done_reg;
    logic [X_W-1:0]      x_reg;
    logic [Y_W-1:0]      y_reg;
    logic [COLOUR_W-1:0] colour_reg;
    logic                plot_reg;

    logic                busy, accept_plot, accept_clear, draw_done, clear_done;
    logic [X_W-1:0]      base_x, dx;
    logic [Y_W-1:0]      base_y, dy;
    logic [X_W:0]        ext_w, sum_x;
    logic [Y_W:0]        ext_h, sum_y;
    logic [COLOUR_W-1:0] pix_colour;
    logic                scan_last, in_screen;

    assign busy = (state_reg != IDLE);

    rect_scan_counter #(.X_W(X_W), .Y_W(Y_W)) u_scan (
        .clock   (iClock),
        .reset_n (iResetn),
        .start   (!busy),
        .enable  (busy),
        .w       (ext_w),
        .h       (ext_h),
        .dx      (dx),
        .dy      (dy),
        .last    (scan_last)
    );

    always_comb begin
        state_next   = state_reg;
        accept_plot  = 1'b0;
        accept_clear = 1'b0;
        draw_done    = 1'b0;
        clear_done   = 1'b0;
        base_x       = '0;
        base_y       = '0;
        ext_w        = (X_W+1)'(BOX_W);
        ext_h        = (Y_W+1)'(BOX_H);
        pix_colour   = COLOUR_W'(BLACK);
        case (state_reg)
            IDLE: begin
                if (iClear) begin
                    accept_clear = 1'b1;
                    state_next   = CLEAR;
                end else if (iPlotBox) begin
                    accept_plot = 1'b1;
                    state_next  = valid_reg ? ERASE : DRAW;
                end
            end
            ERASE: begin
                base_x = old_x_reg;
                base_y = old_y_reg;
                if (scan_last) state_next = DRAW;
            end
            DRAW: begin
                base_x     = new_x_reg;
                base_y     = new_y_reg;
                pix_colour = new_colour_reg;
                if (scan_last) begin
                    draw_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            CLEAR: begin
                ext_w = (X_W+1)'(SCREEN_W);
                ext_h = (Y_W+1)'(SCREEN_H);
                if (scan_last) begin
                    clear_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One extra bit so coordinates past the top of the range still compare as off-screen.
    assign sum_x     = {1'b0, base_x} + {1'b0, dx};
    assign sum_y     = {1'b0, base_y} + {1'b0, dy};
    assign in_screen = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state_reg      <= IDLE;
            old_x_reg      <= '0;
            old_y_reg      <= '0;
            new_x_reg      <= '0;
            new_y_reg      <= '0;
            new_colour_reg <= '0;
            valid_reg      <= 1'b0;
            done_reg       <= 1'b0;
            x_reg          <= '0;
            y_reg          <= '0;
            colour_reg     <= '0;
            plot_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept_plot) begin
                new_x_reg      <= iX;
                new_y_reg      <= iY;
                new_colour_reg <= iColour;
            end
            if (accept_plot || accept_clear) done_reg <= 1'b0;
            if (draw_done) begin
                old_x_reg <= new_x_reg;
                old_y_reg <= new_y_reg;
                valid_reg <= 1'b1;
                done_reg  <= 1'b1;
            end
            if (clear_done) begin
                valid_reg <= 1'b0;
                done_reg  <= 1'b1;
            end
            plot_reg <= busy && in_screen;
            if (busy) begin
                x_reg      <= sum_x[X_W-1:0];
                y_reg      <= sum_y[Y_W-1:0];
                colour_reg <= pix_colour;
            end
        end
    end

    assign oX      = x_reg;
    assign oY      = y_reg;
    assign oColour = colour_reg;
    assign oPlot   = plot_reg;
    assign oBusy   = busy;
    assign oDone   = done_reg;

endmodule

// File: tb/tb_vga_rect_plotter.sv
// Bench for vga_rect_plotter: a 4x4 and an 8x2 instance share stimulus, each checked per cycle against a pixel-list model.
module tb_vga_rect_plotter;

    localparam int SW = 160;
    localparam int SH = 120;

    typedef struct {
        bit plot;
        int x;
        int y;
        int c;
        bit busy;
        bit done;
    } pix_t;

    logic       iClock = 1'b0;
    logic       iResetn = 1'b0;
    logic [7:0] iX = '0;
    logic [6:0] iY = '0;
    logic [2:0] iColour = '0;
    logic       iPlotBox = 1'b0;
    logic       iClear = 1'b0;

    logic [7:0] a_x, b_x;
    logic [6:0] a_y, b_y;
    logic [2:0] a_c, b_c;
    logic       a_plot, b_plot, a_busy, b_busy, a_done, b_done;

    int   checks = 0;
    int   errors = 0;
    pix_t q0[$];
    pix_t q1[$];
    bit   cur_done[2];
    int   plot_cnt[2];

    int   box_w[2] = '{4, 8};
    int   box_h[2] = '{4, 2};
    bit   m_valid[2];
    bit   m_done[2];
    int   m_old_x[2];
    int   m_old_y[2];

    always #5 iClock = ~iClock;

    vga_rect_plotter dut_a (
        .iClock(iClock), .iResetn(iResetn), .iX(iX), .iY(iY), .iColour(iColour),
        .iPlotBox(iPlotBox), .iClear(iClear), .oX(a_x), .oY(a_y), .oColour(a_c),
        .oPlot(a_plot), .oBusy(a_busy), .oDone(a_done)
    );

    vga_rect_plotter #(.BOX_W(8), .BOX_H(2)) dut_b (
        .iClock(iClock), .iResetn(iResetn), .iX(iX), .iY(iY), .iColour(iColour),
        .iPlotBox(iPlotBox), .iClear(iClear), .oX(b_x), .oY(b_y), .oColour(b_c),
        .oPlot(b_plot), .oBusy(b_busy), .oDone(b_done)
    );

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic pix_t mk(bit p, int x, int y, int c, bit b, bit dn);
        pix_t e;
        e.plot = p; e.x = x; e.y = y; e.c = c; e.busy = b; e.done = dn;
        return e;
    endfunction

    task automatic push(input int d, input pix_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Every pixel of the rectangle, row by row; off-screen ones still take a slot.
    task automatic sweep(input int d, input int bx, input int by, input int w, input int h, input int c);
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++) begin
                int sx = bx + xx;
                int sy = by + yy;
                push(d, mk((sx < SW) && (sy < SH), sx & 255, sy & 127, c, 1'b1, 1'b0));
            end
    endtask

    task automatic model_cmd(input int d, input bit clr, input int x, input int y, input int c);
        pix_t e;
        push(d, mk(1'b0, 0, 0, 0, 1'b0, m_done[d]));
        push(d, mk(1'b0, 0, 0, 0, 1'b1, 1'b0));
        if (clr) begin
            sweep(d, 0, 0, SW, SH, 0);
            m_valid[d] = 1'b0;
        end else begin
            if (m_valid[d]) sweep(d, m_old_x[d], m_old_y[d], box_w[d], box_h[d], 0);
            sweep(d, x, y, box_w[d], box_h[d], c);
            m_old_x[d] = x;
            m_old_y[d] = y;
            m_valid[d] = 1'b1;
        end
        if (d == 0) e = q0.pop_back();
        else        e = q1.pop_back();
        e.busy = 1'b0;
        e.done = 1'b1;
        push(d, e);
        m_done[d] = 1'b1;
    endtask

    task automatic cmp_dut(input int d, input logic p, input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input logic b, input logic dn);
        pix_t e;
        bit   have = 1'b0;
        if (d == 0 && q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
        if (d == 1 && q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
        if (p === 1'b1) plot_cnt[d]++;
        if (have) begin
            check($sformatf("dut%0d oPlot", d), p, e.plot);
            check($sformatf("dut%0d oBusy", d), b, e.busy);
            check($sformatf("dut%0d oDone", d), dn, e.done);
            if (e.plot) begin
                check($sformatf("dut%0d oX", d), x, e.x);
                check($sformatf("dut%0d oY", d), y, e.y);
                check($sformatf("dut%0d oColour", d), c, e.c);
            end
            cur_done[d] = e.done;
        end else begin
            check($sformatf("dut%0d idle oPlot", d), p, 0);
            check($sformatf("dut%0d idle oBusy", d), b, 0);
            check($sformatf("dut%0d idle oDone", d), dn, cur_done[d]);
        end
    endtask

    always @(negedge iClock) begin
        cmp_dut(0, a_plot, a_x, a_y, a_c, a_busy, a_done);
        cmp_dut(1, b_plot, b_x, b_y, b_c, b_busy, b_done);
    end

    // Called just after a rising edge; the command is sampled on the next edge.
    task automatic drive_cmd(input bit p, input bit clr, input int x, input int y, input int c);
        iX = 8'(x); iY = 7'(y); iColour = 3'(c);
        iPlotBox = p; iClear = clr;
        $display("cmd plot=%0d clear=%0d x=%0d y=%0d colour=%0d", p, clr, x, y, c);
        for (int d = 0; d < 2; d++) model_cmd(d, clr, x, y, c);
        plot_cnt[0] = 0;
        plot_cnt[1] = 0;
    endtask

    task automatic release_cmd();
        @(posedge iClock); #1;
        iPlotBox = 1'b0;
        iClear   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(posedge iClock); #1;
            n++;
        end while ((q0.size() > 0 || q1.size() > 0) && n < budget);
        check("sweep finished in budget", (q0.size() + q1.size()), 0);
        q0.delete();
        q1.delete();
    endtask

    task automatic check_counts(input string name, input int exp_a, input int exp_b);
        check({name, " dut0 pixel count"}, plot_cnt[0], exp_a);
        check({name, " dut1 pixel count"}, plot_cnt[1], exp_b);
    endtask

    initial begin
        repeat (3) @(posedge iClock);
        #1;
        check("reset oPlot", {a_plot, b_plot}, 0);
        check("reset oBusy", {a_busy, b_busy}, 0);
        check("reset oDone", {a_done, b_done}, 0);
        check("reset oX", a_x, 0);
        check("reset oColour", a_c, 0);
        iResetn = 1'b1;
        @(posedge iClock); #1;

        // First draw: no erase, pin the model against hand-computed pixels
        drive_cmd(1'b1, 1'b0, 10, 20, 5);
        check("model first pixel x", q0[2].x, 10);
        check("model first pixel y", q0[2].y, 20);
        check("model 4x4 last pixel x", q0[17].x, 13);
        check("model 4x4 last pixel y", q0[17].y, 23);
        check("model 8x2 last pixel x", q1[17].x, 17);
        check("model 8x2 last pixel y", q1[17].y, 21);
        check("model first sweep length", q0.size(), 18);
        release_cmd();
        wait_idle(100);
        check_counts("first draw", 16, 16);

        // Erase then draw, 32 contiguous plots
        drive_cmd(1'b1, 1'b0, 50, 60, 2);
        check("model erase colour", q0[2].c, 0);
        check("model draw start x", q0[18].x, 50);
        release_cmd();
        wait_idle(100);
        check_counts("erase+draw", 32, 32);

        // Corner box: only 4 visible pixels of the new box
        drive_cmd(1'b1, 1'b0, 158, 118, 1);
        release_cmd();
        wait_idle(100);
        check_counts("corner clip", 20, 20);

        // Clear wins over plot
        drive_cmd(1'b1, 1'b1, 0, 0, 7);
        check("model clear length", q0.size(), 19202);
        check("model clear last x", q0[19201].x, 159);
        check("model clear last y", q0[19201].y, 119);
        release_cmd();
        wait_idle(19400);
        check_counts("clear", 19200, 19200);

        drive_cmd(1'b1, 1'b0, 30, 40, 6);
        release_cmd();
        wait_idle(100);
        check_counts("draw after clear", 16, 16);

        // A command mid-draw is ignored
        drive_cmd(1'b1, 1'b0, 70, 80, 7);
        release_cmd();
        repeat (20) @(posedge iClock);
        #1;
        iPlotBox = 1'b1;
        iX = 8'd0;
        check("busy during ignored cmd", {a_busy, b_busy}, 3);
        @(posedge iClock); #1;
        iPlotBox = 1'b0;
        wait_idle(100);
        check_counts("ignored cmd", 32, 32);
        repeat (5) @(posedge iClock);
        #1;
        check("done held after ignored cmd", {a_done, b_done}, 3);

        // Asynchronous reset in the middle of an erase
        drive_cmd(1'b1, 1'b0, 5, 5, 3);
        release_cmd();
        repeat (6) @(posedge iClock);
        #3;
        iResetn = 1'b0;
        #1;
        check("async reset oPlot", {a_plot, b_plot}, 0);
        check("async reset oBusy", {a_busy, b_busy}, 0);
        check("async reset oDone", {a_done, b_done}, 0);
        q0.delete();
        q1.delete();
        cur_done[0] = 1'b0; cur_done[1] = 1'b0;
        m_valid[0]  = 1'b0; m_valid[1]  = 1'b0;
        m_done[0]   = 1'b0; m_done[1]   = 1'b0;
        repeat (2) @(posedge iClock);
        #1;
        iResetn = 1'b1;
        @(posedge iClock); #1;

        drive_cmd(1'b1, 1'b0, 1, 2, 4);
        check("model 8x2 second row x", q1[10].x, 1);
        check("model 8x2 second row y", q1[10].y, 3);
        release_cmd();
        wait_idle(100);
        check_counts("draw after reset", 16, 16);
        repeat (4) @(posedge iClock);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_rect_plotter.md
Name: vga_rect_plotter

Overview:
- Parametrised successor to the fixed 4x4 box drawer for the VGA adapter path.
- Draws a filled BOX_W x BOX_H rectangle at a latched (x,y) in a latched colour, one pixel per clock.
- Before each new draw, automatically erases the previously drawn rectangle by repainting it black.
- Also supports a full-screen clear command. Pixels outside the screen are clipped. Sits between user/game logic and the VGA adapter's pixel-write port.

Parameters:
- X_W, 8, width of x coordinate
- Y_W, 7, width of y coordinate
- COLOUR_W, 3, colour width
- BOX_W, 4, rectangle width in pixels (1..2**X_W)
- BOX_H, 4, rectangle height in pixels (1..2**Y_W)
- SCREEN_W, 160, visible width; x >= SCREEN_W is clipped
- SCREEN_H, 120, visible height; y >= SCREEN_H is clipped

Ports:
- iClock  in  1  clock; all state changes on rising edge
- iResetn  in  1  reset, asynchronous, active-low
- iX  in  X_W  rectangle top-left x
- iY  in  Y_W  rectangle top-left y
- iColour  in  COLOUR_W  rectangle colour
- iPlotBox  in  1  draw command; sampled only in IDLE
- iClear  in  1  clear-screen command; sampled only in IDLE
- oX  out  X_W  pixel x
- oY  out  Y_W  pixel y
- oColour  out  COLOUR_W  pixel colour
- oPlot  out  1  pixel write strobe
- oBusy  out  1  high while not in IDLE
- oDone  out  1  sticky completion flag

Behaviour:
- Reset (asynchronous, any time, including mid-sweep):
  - All outputs are 0.
  - State is IDLE.
  - The valid flag (a previous rectangle exists on screen) is cleared.
  - Latched old/new x, y and colour are 0.
- States: IDLE, ERASE, DRAW, CLEAR.
- IDLE:
  - iClear=1 takes priority: go to CLEAR, clear oDone.
  - Otherwise iPlotBox=1: latch iX, iY, iColour as new_*, clear oDone. Go to ERASE if valid=1, else DRAW.
  - Commands arriving in any other state are ignored, not queued.
- Scan order is row-major: x offset is the inner loop, y offset the outer. Offsets start at 0.
- ERASE:
  - Emits BOX_W*BOX_H pixels at old_x+dx, old_y+dy with colour 0.
  - After the last pixel, go to DRAW.
- DRAW:
  - Emits BOX_W*BOX_H pixels at new_x+dx, new_y+dy with new_colour.
  - After the last pixel: copy new_x/new_y to old_x/old_y, set valid=1, set oDone=1, go to IDLE.
- CLEAR:
  - Emits SCREEN_W*SCREEN_H pixels from (0,0) with colour 0.
  - After the last pixel: valid=0, oDone=1, go to IDLE.
- Output timing:
  - oX, oY, oColour and oPlot are registered, one cycle behind the scan counter.
  - With command acceptance at edge k, the first pixel is valid after edge k+1.
  - Pixels are then contiguous, one per cycle, with no gap between ERASE and DRAW.
  - oPlot=0 after the edge on which the final pixel's cycle ends.
- Arithmetic: coordinates are computed as base+offset in X_W+1 / Y_W+1 bits.
  - If the sum is >= SCREEN_W or >= SCREEN_H (including overflow past 2**X_W), that pixel has oPlot=0.
  - The scan still consumes the cycle, so sweep length is constant.
  - oX/oY carry the truncated low bits.
- oBusy is 1 in ERASE, DRAW and CLEAR, and 0 in IDLE. A command is accepted only when oBusy=0.
- oDone stays high until the next accepted command or reset.
- iPlotBox and iClear are level-sampled. Holding iPlotBox high causes back-to-back redraws, each with an erase.

Decomposition:
- Package vga_plot_pkg:
  - state encoding localparams (IDLE=0, ERASE=1, DRAW=2, CLEAR=3)
  - default SCREEN_W/SCREEN_H/COLOUR_W constants
  - BLACK colour constant
- One sub-module, rect_scan_counter:
  - Parameters: X_W, Y_W.
  - Inputs: start, enable, run-time extent w/h.
  - Outputs: dx, dy, last.
  - Reused for box sweeps (extent BOX_W/BOX_H) and screen clear (extent SCREEN_W/SCREEN_H).

Test Plan:
- Reset then iPlotBox with iX=10, iY=20, iColour=3'b101 for 1 cycle:
  - No erase phase.
  - Exactly 16 oPlot pulses, in order (10,20),(11,20),(12,20),(13,20),(10,21)...(13,23), all colour 5.
  - oDone=1 on the cycle after the last pixel.
- Second command iX=50, iY=60, iColour=3'b010:
  - 16 pixels at (10..13,20..23) colour 0, immediately followed by 16 pixels at (50..53,60..63) colour 2.
  - 32 contiguous plots total.
- iX=158, iY=118, 4x4 box:
  - Only the 4 pixels at x in {158,159}, y in {118,119} have oPlot=1.
  - The sweep still lasts 16 cycles.
- iClear=1 and iPlotBox=1 asserted together in IDLE:
  - CLEAR wins: 19200 pixels, all colour 0, last pixel (159,119).
  - A following iPlotBox draws with no erase phase.
- iPlotBox pulsed during DRAW: ignored; pixel count is unchanged and oBusy stays 1.
- iResetn dropped asynchronously mid-ERASE:
  - oPlot, oBusy and oDone go 0 immediately.
  - The next iPlotBox draws with no erase, since valid was cleared.
  - Repeat with BOX_W=8, BOX_H=2, checking 16 pixels in 2 rows of 8.
